dequantize_unpack: RTL and testbench
====================================

DEQUANTIZE_UNPACK -- requirements
Module: dequantize_unpack

Interface
REQ-001 The block SHALL have parameter FC1_SHIFT, default 6, the left-shift amount applied when the latched layer is fc1.
REQ-002 The block SHALL have parameter FC2_SHIFT, default 5, the left-shift amount applied when the latched layer is fc2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 srstn  input  1  reset, asynchronous, active-low.
REQ-005 fc_state  input  1  layer select (0 = fc1, 1 = fc2); sampled only on an input transfer.
REQ-006 in_valid  input  1  in_data/fc_state valid.
REQ-007 in_ready  output  1  block can accept a packed word this cycle.
REQ-008 in_data  input  32  four signed int8 lanes; lane0 = [7:0] (emitted first) through lane3 = [31:24].
REQ-009 out_valid  output  1  out_data/out_last valid.
REQ-010 out_ready  input  1  downstream accepts the current beat.
REQ-011 out_data  output  32  signed dequantized lane value.
REQ-012 out_last  output  1  high on the lane3 beat of each word.

Function
REQ-013 States SHALL be IDLE (no word held) and BUSY (word held, lane index 0..3 valid).
REQ-014 Input transfer SHALL occur when in_valid && in_ready; it latches in_data, latches fc_state, and sets lane index 0.
REQ-015 in_ready SHALL be 1 in IDLE, and in BUSY only when lane index = 3 && out_ready = 1; otherwise 0.
REQ-016 out_valid SHALL equal (state == BUSY).
REQ-017 Output transfer SHALL occur when out_valid && out_ready; it advances lane index by 1 (0..2), or completes the word at lane 3.
REQ-018 Word completion with a simultaneous input transfer SHALL move to BUSY lane 0 of the new word with no bubble cycle; completion without one SHALL return to IDLE.
REQ-019 While out_valid && !out_ready, out_data, out_last and lane index SHALL hold unchanged.
REQ-020 out_data SHALL be the selected lane sign-extended to 32 bits, then shifted left by FC1_SHIFT (latched fc_state = 0) or FC2_SHIFT (latched fc_state = 1); no rounding, no saturation (result always fits).
REQ-021 out_data and out_last SHALL be driven only from internal registers, with no combinational path from in_* inputs.
REQ-022 out_last SHALL be 1 exactly when out_valid and lane index = 3.
REQ-023 fc_state changes while a word is BUSY SHALL NOT affect that word's remaining beats.
REQ-024 Sustained throughput SHALL be one output beat per cycle (one input word per 4 cycles) when in_valid and out_ready are held high.

Reset
REQ-025 srstn = 0 SHALL immediately, without waiting for clk, force IDLE, lane index 0, word register 0, latched fc_state 0.
REQ-026 During and after reset: out_valid = 0, out_data = 0, out_last = 0, in_ready = 1.
REQ-027 A word in progress at reset assertion SHALL be discarded; no remaining beats are emitted after release.

Verification
REQ-028 fc_state=0, in_data=32'h807F01FF, out_ready=1 -> 4 consecutive beats 32'hFFFFFFC0, 32'h00000040, 32'h00001FC0, 32'hFFFFE000; out_last only on the 4th.
REQ-029 fc_state=1, same word -> 32'hFFFFFFE0, 32'h00000020, 32'h00000FE0, 32'hFFFFF000.
REQ-030 Two words presented back-to-back with in_valid held and out_ready=1 -> 8 contiguous beats, no bubble; in_ready high only in the cycle of each lane3 beat (and in IDLE).
REQ-031 out_ready=0 for 3 cycles while lane1 of 32'h807F01FF (fc1) is presented -> out_data holds 32'h00000040, out_valid stays 1, next beat after release is 32'h00001FC0.
REQ-032 srstn pulsed low asynchronously after lane1 is emitted -> out_valid falls before the next clk edge; in_ready=1; a new word after release starts at lane0.
REQ-033 fc_state toggled 0->1 after an fc1 word is accepted -> all 4 beats use shift 6; the next accepted word uses shift 5.

Source files
------------

// File: rtl/dequantize_unpack.sv
// Unpacks a 32-bit word of four signed int8 lanes into four sequential beats,
// each sign-extended and left-shifted by a per-layer dequantization amount.
module dequantize_unpack #(
    parameter int unsigned FC1_SHIFT = 6,
    parameter int unsigned FC2_SHIFT = 5
) (
    input  logic        clk,
    input  logic        srstn,
    input  logic        fc_state,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e      state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] word_q, word_d;
    logic        fc_q, fc_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_last_q, out_last_d;

    logic        in_xfer;
    logic        out_xfer;
    logic [7:0]  lane_byte;
    logic [31:0] lane_ext;

    assign out_valid = (state_q == StBusy);
    assign in_ready  = (state_q == StIdle) || ((lane_q == 2'd3) && out_ready);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        word_d  = word_q;
        fc_d    = fc_q;
        if (in_xfer) begin
            // Covers both the idle load and the no-bubble hand-over at lane 3.
            state_d = StBusy;
            lane_d  = 2'd0;
            word_d  = in_data;
            fc_d    = fc_state;
        end else if (out_xfer) begin
            if (lane_q == 2'd3) begin
                state_d = StIdle;
                lane_d  = 2'd0;
            end else begin
                lane_d = lane_q + 2'd1;
            end
        end
    end

    // Outputs are precomputed from next-state so they leave the block registered.
    always_comb begin
        lane_byte = 8'h00;
        unique case (lane_d)
            2'd0: lane_byte = word_d[7:0];
            2'd1: lane_byte = word_d[15:8];
            2'd2: lane_byte = word_d[23:16];
            2'd3: lane_byte = word_d[31:24];
            default: lane_byte = 8'h00;
        endcase
        lane_ext   = {{24{lane_byte[7]}}, lane_byte};
        out_data_d = 32'h0;
        out_last_d = 1'b0;
        if (state_d == StBusy) begin
            out_data_d = fc_d ? (lane_ext << FC2_SHIFT) : (lane_ext << FC1_SHIFT);
            out_last_d = (lane_d == 2'd3);
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state_q    <= StIdle;
            lane_q     <= 2'd0;
            word_q     <= 32'h0;
            fc_q       <= 1'b0;
            out_data_q <= 32'h0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            word_q     <= word_d;
            fc_q       <= fc_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
        end
    end

endmodule

// File: tb/tb_dequantize_unpack.sv
// Randomized and directed bench for dequantize_unpack against a queue-of-beats model.
module tb_dequantize_unpack;

    localparam int SH1 = 6;
    localparam int SH2 = 5;
    localparam logic [31:0] W = 32'h807F01FF;

    logic        clk;
    logic        srstn;
    logic        fc_state;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] obs_data;
    logic        obs_valid;
    logic        obs_rdy;

    dequantize_unpack dut (
        .clk      (clk),
        .srstn    (srstn),
        .fc_state (fc_state),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Dequantized value of one lane computed with plain integer arithmetic.
    function automatic logic [31:0] deq(input logic [31:0] w, input int lane, input logic fc);
        logic [7:0] b;
        int v;
        b = w[lane*8 +: 8];
        v = int'($signed(b));
        return v * (fc ? (1 << SH2) : (1 << SH1));
    endfunction

    // One clock: drive inputs, check outputs against the model, then advance the model.
    task automatic cycle(input logic v, input logic [31:0] d, input logic fc, input logic rdy);
        logic busy;
        logic exp_rdy;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        fc_state  = fc;
        out_ready = rdy;
        #1;
        busy    = (exp_q.size() != 0);
        exp_rdy = !busy || ((exp_q.size() == 1) && rdy);
        check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
        check_eq("out_valid", 32'(out_valid), 32'(busy));
        check_eq("out_data", out_data, busy ? exp_q[0] : 32'h0);
        check_eq("out_last", 32'(out_last), 32'(busy && exp_q.size() == 1));
        obs_data  = out_data;
        obs_valid = out_valid;
        obs_rdy   = in_ready;
        if (busy && rdy) void'(exp_q.pop_front());
        if (v && exp_rdy) begin
            for (int l = 0; l < 4; l++) exp_q.push_back(deq(d, l, fc));
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 8 && exp_q.size() != 0; k++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    logic [31:0] fc1_beats [4];
    logic [31:0] fc2_beats [4];
    int vcount;

    initial begin
        fc1_beats[0] = 32'hFFFFFFC0; fc1_beats[1] = 32'h00000040;
        fc1_beats[2] = 32'h00001FC0; fc1_beats[3] = 32'hFFFFE000;
        fc2_beats[0] = 32'hFFFFFFE0; fc2_beats[1] = 32'h00000020;
        fc2_beats[2] = 32'h00000FE0; fc2_beats[3] = 32'hFFFFF000;

        srstn = 1'b0; in_valid = 1'b0; in_data = 32'h0; fc_state = 1'b0; out_ready = 1'b0;
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", out_data, 32'h0);
        check_eq("rst_out_last", 32'(out_last), 32'd0);
        repeat (2) @(negedge clk);
        srstn = 1'b1;

        // fc1 and fc2 reference vectors
        cycle(1'b1, W, 1'b0, 1'b1);
        for (int l = 0; l < 4; l++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1);
            check_eq("fc1_vec", obs_data, fc1_beats[l]);
        end
        cycle(1'b1, W, 1'b1, 1'b1);
        for (int l = 0; l < 4; l++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1);
            check_eq("fc2_vec", obs_data, fc2_beats[l]);
        end
        drain();

        // Back-to-back words: 8 contiguous beats, no bubble
        vcount = 0;
        cycle(1'b1, W, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 32'h12345678, 1'b1, 1'b1);
            if (obs_valid) vcount++;
            if (k == 3) check_eq("b2b_ready_lane3", 32'(obs_rdy), 32'd1);
            if (k == 1) check_eq("b2b_ready_lane1", 32'(obs_rdy), 32'd0);
        end
        check_eq("b2b_beats", 32'(vcount), 32'd8);
        drain();

        // Stall on lane1
        cycle(1'b1, W, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b0);
            check_eq("stall_hold", obs_data, 32'h00000040);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("stall_next", obs_data, 32'h00001FC0);
        drain();

        // Asynchronous reset mid-word discards the rest
        cycle(1'b1, W, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        #2 srstn = 1'b0;
        #1;
        check_eq("arst_out_valid", 32'(out_valid), 32'd0);
        check_eq("arst_in_ready", 32'(in_ready), 32'd1);
        check_eq("arst_out_data", out_data, 32'h0);
        exp_q.delete();
        @(negedge clk);
        srstn = 1'b1;
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b1, W, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("arst_new_lane0", obs_data, fc2_beats[0]);
        drain();

        // fc_state toggled mid-word only affects the next word
        cycle(1'b1, W, 1'b0, 1'b1);
        for (int l = 0; l < 4; l++) begin
            cycle(l == 3, W, 1'b1, 1'b1);
            check_eq("fc_toggle_old", obs_data, fc1_beats[l]);
        end
        for (int l = 0; l < 4; l++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1);
            check_eq("fc_toggle_new", obs_data, fc2_beats[l]);
        end
        drain();

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            cycle(($urandom % 4) != 0, $urandom, 1'($urandom), ($urandom % 3) != 0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
